// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite memory slave: 32-bit word storage with byte-lane writes,
// configurable wait states and a two-cycle ERROR response for illegal transfers.
module ahb_lite_mem_slave #(
    parameter int ADDR_WIDTH      = 16,
    parameter int MEM_DEPTH_WORDS = 1024,
    parameter int WAIT_STATES     = 0
) (
    input  logic                  CLK,
    input  logic                  RESETN,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADYIN,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [31:0]           HRDATA
);

    localparam int         IDX_W     = (MEM_DEPTH_WORDS > 1) ? $clog2(MEM_DEPTH_WORDS) : 1;
    // Counter is loaded with WAIT_STATES-1 so that it spends exactly WAIT_STATES cycles in WAIT.
    localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;

    state_t           state;
    logic [2:0]       wait_cnt;
    logic             dp_vld;      // an OKAY data phase is in flight
    logic             write_q;
    logic [1:0]       size_q;
    logic [1:0]       off_q;
    logic [IDX_W-1:0] idx_q;
    logic             hready_q;
    logic             hresp_q;

    logic [31:0]      mem [MEM_DEPTH_WORDS];

    logic             trans_active;
    logic             accept;
    logic             addr_err;
    logic [31:0]      word_idx;
    logic             complete;
    logic [3:0]       lane_en;

    assign trans_active = (HTRANS == 2'b10) || (HTRANS == 2'b11);
    // Only sample a new address phase while our own data phase is not being extended.
    assign accept       = HSEL && HREADYIN && trans_active && hready_q;
    assign complete     = dp_vld && hready_q;

    // Decide at address time whether the transfer is illegal for this slave.
    always_comb begin
        word_idx = 32'(HADDR[ADDR_WIDTH-1:2]);
        addr_err = 1'b0;
        if (HSIZE > 3'd2)                          addr_err = 1'b1;
        if (HSIZE == 3'd1 && HADDR[0])             addr_err = 1'b1;
        if (HSIZE == 3'd2 && HADDR[1:0] != 2'b00)  addr_err = 1'b1;
        if (word_idx >= 32'(MEM_DEPTH_WORDS))      addr_err = 1'b1;
    end

    // Response FSM with registered HREADYOUT/HRESP and address-phase capture.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state    <= IDLE;
            wait_cnt <= 3'd0;
            dp_vld   <= 1'b0;
            write_q  <= 1'b0;
            size_q   <= 2'd0;
            off_q    <= 2'd0;
            idx_q    <= '0;
            hready_q <= 1'b1;
            hresp_q  <= 1'b0;
        end else begin
            case (state)
                WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        state    <= IDLE;
                        hready_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                ERR1: begin
                    state    <= ERR2;
                    hready_q <= 1'b1;
                    hresp_q  <= 1'b1;
                end
                default: begin
                    // IDLE and ERR2 both end a data phase, so both may take a new address phase.
                    if (accept) begin
                        write_q <= HWRITE;
                        size_q  <= HSIZE[1:0];
                        off_q   <= HADDR[1:0];
                        idx_q   <= HADDR[IDX_W+1:2];
                        if (addr_err) begin
                            state    <= ERR1;
                            hready_q <= 1'b0;
                            hresp_q  <= 1'b1;
                            dp_vld   <= 1'b0;
                        end else if (WAIT_STATES > 0) begin
                            state    <= WAIT;
                            wait_cnt <= WAIT_LOAD;
                            hready_q <= 1'b0;
                            hresp_q  <= 1'b0;
                            dp_vld   <= 1'b1;
                        end else begin
                            state    <= IDLE;
                            hready_q <= 1'b1;
                            hresp_q  <= 1'b0;
                            dp_vld   <= 1'b1;
                        end
                    end else begin
                        state    <= IDLE;
                        hready_q <= 1'b1;
                        hresp_q  <= 1'b0;
                        dp_vld   <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Little-endian byte-lane enables for the captured size/offset.
    always_comb begin
        case (size_q)
            2'd0:    lane_en = 4'b0001 << off_q;
            2'd1:    lane_en = off_q[1] ? 4'b1100 : 4'b0011;
            default: lane_en = 4'b1111;
        endcase
    end

    // Commit write data on the edge that completes the data phase; storage has no reset.
    always_ff @(posedge CLK) begin
        if (complete && write_q) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

    assign HREADYOUT = hready_q;
    assign HRESP     = hresp_q;
    // Read data is only visible in the completing cycle, so a read right after a write sees the new word.
    assign HRDATA    = (complete && !write_q) ? mem[idx_q] : 32'd0;

endmodule
